// File: rtl/bin_bcd_convert_pkg.sv
// Shared constants for the ALU-to-display path: state encodings,
// display limits and the overflow glyph.
package bin_bcd_convert_pkg;

  localparam int BIN_W_DEF  = 16;
  localparam int DIGITS_DEF = 4;

  // Largest value the 4-digit display can show (10^DIGITS - 1).
  localparam int MAX_VAL = 9999;

  // Nibble replicated across the display when the value does not fit.
  localparam logic [3:0] OVF_NIBBLE = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digits needed to hold any bin_w-bit value: ceil(bin_w * log10(2)).
  function automatic int acc_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_bcd_convert_if.sv
// Request/result bundle between the ALU result path and the converter.
interface bin_bcd_convert_if
  import bin_bcd_convert_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
);

  logic                  Bin_Bcd_start;
  logic [BIN_W-1:0]      Bin_Bcd_bin;
  logic                  Bin_Bcd_busy;
  logic                  Bin_Bcd_done;
  logic                  Bin_Bcd_ovf;
  logic [4*DIGITS-1:0]   Bin_Bcd_bcd;

  modport master (
    output Bin_Bcd_start, Bin_Bcd_bin,
    input  Bin_Bcd_busy, Bin_Bcd_done, Bin_Bcd_ovf, Bin_Bcd_bcd
  );

  modport slave (
    input  Bin_Bcd_start, Bin_Bcd_bin,
    output Bin_Bcd_busy, Bin_Bcd_done, Bin_Bcd_ovf, Bin_Bcd_bcd
  );

endinterface

// File: rtl/bin_bcd_convert_bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? (in_i + 4'd3) : in_i;

endmodule

// File: rtl/bin_bcd_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the seven-segment display data bus.
module bin_bcd_convert
  import bin_bcd_convert_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic               Bin_Bcd_clk_100MHz,
  input  logic               Bin_Bcd_reset_n,
  bin_bcd_convert_if.slave   bus
);

  localparam int ACC_D = acc_digits(BIN_W);
  localparam int ACC_W = 4 * ACC_D;
  localparam int OUT_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shifted;
  logic [BIN_W-1:0]   shift_shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_lat_q, ovf_lat_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   bcd_q, bcd_d;

  // One correction cell per accumulator digit.
  for (genvar gi = 0; gi < ACC_D; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .in_i  (acc_q[4*gi +: 4]),
      .out_o (acc_adj[4*gi +: 4])
    );
  end

  // The adjusted top bit falls off the shift; the accumulator is sized so
  // it is always zero for any BIN_W-bit input.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_adj[ACC_W-1];

  assign {acc_shifted, shift_shifted} = {acc_adj[ACC_W-2:0], shift_q, 1'b0};

  // Next-state and datapath control; every target defaults to hold.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.Bin_Bcd_start) begin
          shift_d   = bus.Bin_Bcd_bin;
          acc_d     = '0;
          ovf_lat_d = (32'(bus.Bin_Bcd_bin) > MAX_VAL);
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_shifted;
        shift_d = shift_shifted;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Publish on the edge entering DONE so the result is visible
          // in the same cycle as the done pulse.
          ovf_d   = ovf_lat_q;
          bcd_d   = ovf_lat_q ? {DIGITS{OVF_NIBBLE}} : acc_shifted[OUT_W-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and display registers.
  always_ff @(posedge Bin_Bcd_clk_100MHz or negedge Bin_Bcd_reset_n) begin
    if (!Bin_Bcd_reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bus.Bin_Bcd_busy = (state_q == SHIFT);
  assign bus.Bin_Bcd_done = (state_q == DONE);
  assign bus.Bin_Bcd_ovf  = ovf_q;
  assign bus.Bin_Bcd_bcd  = bcd_q;

endmodule

// File: doc/bin_bcd_convert.md
Name: bin_bcd_convert

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display driver in the multi-function ALU design.
- Takes the ALU's unsigned binary result and converts it with shift-and-add-3 (double dabble), one bit per clock.
- Presents four packed BCD nibbles, held stable, on the 16-bit data bus the display driver multiplexes.
- Out-of-range results display as "EEEE".

Parameters:
- BIN_W, 16, width of the binary input; also the number of SHIFT cycles per conversion.
- DIGITS, 4, number of BCD digits presented; output width = 4*DIGITS.
- MAX_VAL, 9999, largest displayable value; must equal 10^DIGITS-1.
- OVF_NIBBLE, 4'hE, nibble replicated across the output on overflow.

Ports:
- Bin_Bcd_clk_100MHz  input  1  system clock, 100 MHz; all state changes on its rising edge.
- Bin_Bcd_reset_n  input  1  asynchronous, active-low reset.
- Bin_Bcd_start  input  1  one-cycle request; samples Bin_Bcd_bin.
- Bin_Bcd_bin  input  BIN_W  unsigned binary value to convert.
- Bin_Bcd_busy  output  1  high while a conversion is in progress.
- Bin_Bcd_done  output  1  one-cycle pulse when Bin_Bcd_bcd / Bin_Bcd_ovf update.
- Bin_Bcd_ovf  output  1  registered; 1 if the last converted value exceeded MAX_VAL.
- Bin_Bcd_bcd  output  4*DIGITS  packed BCD, most significant digit in the top nibble; feeds the display data bus.

Behaviour:
- Reset (Bin_Bcd_reset_n low, asynchronous): state=IDLE, busy=0, done=0, ovf=0, bcd=0 (display shows 0000), internal shift registers and counter=0. Reset mid-conversion aborts it; no done pulse is produced.
- FSM states:
  - IDLE: busy=0. If start=1: latch bin into the shift register, clear the internal BCD accumulator, latch the overflow flag (bin > MAX_VAL), load counter=BIN_W, and go to SHIFT.
  - SHIFT: busy=1. Each cycle, first add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by 1 and decrement the counter. When the counter reaches 1, perform the last shift and go to DONE.
  - DONE: busy=0 and done=1 for exactly this cycle; bcd and ovf are updated in this cycle. Go to IDLE.
- Internal accumulator: ceil(BIN_W*log10(2)) digits, which is 5 digits for BIN_W=16. Only the low DIGITS digits are driven out.
- Output select:
  - ovf=0: bcd = low DIGITS digits of the accumulator.
  - ovf=1: bcd = OVF_NIBBLE replicated, i.e. 16'hEEEE.
- Latency: start sampled at edge N; busy high for cycles N+1..N+BIN_W; done high in cycle N+BIN_W+1, which is cycle 17 for defaults. Latency is independent of the input value, including the overflow case.
- start while in SHIFT: ignored; the conversion in progress is not disturbed.
- start during the DONE cycle: ignored. The next start is accepted in IDLE, so the minimum start-to-start spacing is BIN_W+2 cycles.
- bcd and ovf hold their values between conversions, so the display stays stable. Bin_Bcd_bin may change freely after the start edge.
- Boundaries: bin=0 -> 0000; bin=MAX_VAL -> 9999 with ovf=0; bin=MAX_VAL+1 -> EEEE with ovf=1; bin=all-ones (65535) -> EEEE with ovf=1.

Decomposition:
- Shared constants include file, used by every ALU-display-path block:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - OVF_NIBBLE
  - MAX_VAL
- One natural sub-module: bcd_digit_adj. It is a combinational 4-bit cell: out = in + 3 when in >= 5, otherwise in. Instantiate it once per accumulator digit with a generate loop.
- The top level contains the FSM, the shift/counter datapath, and the output registers.

Test Plan:
- Reset then idle: bcd=16'h0000, ovf=0, busy=0, done=0; nothing changes over 100 cycles with start=0.
- start with bin=16'h04D2 (1234): busy high for cycles 1..16; done pulse in cycle 17 with bcd=16'h1234 and ovf=0. Repeat with bin=0 -> 16'h0000.
- Boundaries:
  - bin=9999 -> bcd=16'h9999, ovf=0.
  - bin=10000 -> bcd=16'hEEEE, ovf=1.
  - bin=65535 -> bcd=16'hEEEE, ovf=1.
  - Each done pulse arrives in cycle 17.
- Start during busy: start with bin=42, pulse start with bin=7 at cycle 5 and again in the done cycle -> exactly one done pulse, bcd=16'h0042; the bcd value holds afterwards.
- Reset mid-operation: start with bin=1234, assert reset_n=0 at cycle 8 -> bcd=0 and busy=0 immediately (asynchronous); no done pulse. A fresh start with bin=5678 after release gives 16'h5678 at cycle 17.
- Back-to-back: start bin=321, then start bin=9876 in the first IDLE cycle after done -> two done pulses 18 cycles apart, with bcd=16'h0321 then 16'h9876.
